gcore_fetch: RTL and testbench

GCORE_FETCH -- requirements
Module: gcore_fetch

---
 rtl/gcore_pkg.sv | 24 ++
 rtl/gcore_fetch.sv | 81 ++++++++
 tb/tb_gcore_fetch.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gcore_pkg.sv
// Shared definitions for the gcore decoder and fetch unit:
// opcode byte values and the fetch FSM state encoding.
package gcore_pkg;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LDA  = 8'h01;
   localparam logic [7:0] OP_STA  = 8'h02;
   localparam logic [7:0] OP_ADD  = 8'h03;
   localparam logic [7:0] OP_SUB  = 8'h04;
   localparam logic [7:0] OP_AND  = 8'h05;
   localparam logic [7:0] OP_OR   = 8'h06;
   localparam logic [7:0] OP_XOR  = 8'h07;
   localparam logic [7:0] OP_SLL  = 8'h08;
   localparam logic [7:0] OP_JUMP = 8'h09;
   localparam logic [7:0] OP_BZ   = 8'h0A;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FETCH_OP  = 2'd1,
      FETCH_ARG = 2'd2,
      ISSUE     = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/gcore_fetch.sv
// Instruction fetch for gcore: reads a two-byte instruction (opcode, operand),
// presents it to execute, then advances or redirects the program counter.
module gcore_fetch
   import gcore_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   output logic       imem_req,
   output logic [7:0] imem_addr,
   input  logic       imem_ack,
   input  logic [7:0] imem_rdata,
   output logic [7:0] op,
   output logic [7:0] arg,
   output logic       op_valid,
   input  logic       op_ready,
   input  logic       jump,
   input  logic       brach,
   input  logic       acc_zero,
   output logic [7:0] pc
);

   fetch_state_t state, state_d;
   logic [7:0]   pc_d, op_d, arg_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= RESET_PC;
         op    <= OP_NOP;
         arg   <= 8'h00;
      end else begin
         state <= state_d;
         pc    <= pc_d;
         op    <= op_d;
         arg   <= arg_d;
      end
   end

   // run is only consulted from IDLE and at acceptance, so a started fetch always issues.
   always_comb begin
      state_d   = state;
      pc_d      = pc;
      op_d      = op;
      arg_d     = arg;
      imem_req  = 1'b0;
      imem_addr = pc;
      op_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (run) state_d = FETCH_OP;
         end
         FETCH_OP: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               op_d    = imem_rdata;
               state_d = FETCH_ARG;
            end
         end
         FETCH_ARG: begin
            imem_req  = 1'b1;
            imem_addr = pc + 8'd1;
            if (imem_ack) begin
               arg_d   = imem_rdata;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            op_valid = 1'b1;
            if (op_ready) begin
               pc_d    = (jump || (brach && acc_zero)) ? arg : pc + 8'd2;
               state_d = run ? FETCH_OP : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gcore_fetch.sv
// Self-checking bench for gcore_fetch: a table of instructions walked through a
// small memory model, a scoreboard of issued instructions, and corner sequences.
module tb_gcore_fetch;
   import gcore_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, run, imem_req, imem_ack, op_valid, op_ready;
   logic       jump, brach, acc_zero;
   logic [7:0] imem_addr, imem_rdata, op, arg, pc;

   logic [7:0] mem [256];
   int         wait_states;
   int         wait_cnt;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] op;
      logic [7:0] arg;
      logic       jump;
      logic       brach;
      logic       acc_zero;
      logic [7:0] next_pc;
   } vec_t;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] op;
      logic [7:0] arg;
   } issue_t;

   vec_t   vecs[13];
   issue_t sb[$];

   gcore_fetch #(.RESET_PC(8'h10)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .op(op), .arg(arg), .op_valid(op_valid), .op_ready(op_ready),
      .jump(jump), .brach(brach), .acc_zero(acc_zero), .pc(pc)
   );

   always #5 clk = ~clk;

   // Memory acks after wait_states stalled cycles; zero means same-cycle ack.
   assign imem_ack   = imem_req && (wait_cnt >= wait_states);
   assign imem_rdata = mem[imem_addr];

   always @(posedge clk) begin
      if (!rst_n || !imem_req || imem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every accepted issue must match the oldest expected instruction.
   always @(negedge clk) begin
      if (rst_n && op_valid && op_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_issue actual=%h expected=none", op);
         end else begin
            issue_t e;
            e = sb.pop_front();
            checkOutput("sb_op", op, e.op);
            checkOutput("sb_arg", arg, e.arg);
            checkOutput("sb_pc", pc, e.pc);
         end
      end
   end

   task automatic applyStimulus(input int i, input logic last);
      vec_t v;
      int   n;
      v = vecs[i];
      sb.push_back('{v.pc, v.op, v.arg});
      n = 0;
      while (!op_valid && n < 20) begin
         tick();
         n++;
      end
      checkOutput("op_valid_wait", {7'd0, op_valid}, 8'd1);
      checkOutput("issue_pc", pc, v.pc);
      jump     = v.jump;
      brach    = v.brach;
      acc_zero = v.acc_zero;
      op_ready = 1'b1;
      run      = !last;
      tick();
      op_ready = 1'b0;
      jump     = 1'b1;
      brach    = 1'b1;
      acc_zero = 1'b1;
      checkOutput("next_pc", pc, v.next_pc);
      if (run) checkOutput("next_addr", imem_addr, v.next_pc);
      else     checkOutput("idle_req", {7'd0, imem_req}, 8'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{8'h10, OP_LDA,  8'h33,  1'b0, 1'b0, 1'b0, 8'h12};
      vecs[1]  = '{8'h12, OP_JUMP, 8'h20,  1'b1, 1'b0, 1'b0, 8'h20};
      vecs[2]  = '{8'h20, OP_ADD,  8'h05,  1'b0, 1'b0, 1'b0, 8'h22};
      vecs[3]  = '{8'h22, OP_JUMP, 8'h30,  1'b1, 1'b0, 1'b0, 8'h30};
      vecs[4]  = '{8'h30, OP_BZ,   8'h50,  1'b0, 1'b1, 1'b0, 8'h32};
      vecs[5]  = '{8'h32, OP_BZ,   8'h50,  1'b0, 1'b1, 1'b1, 8'h50};
      vecs[6]  = '{8'h50, OP_JUMP, 8'h40,  1'b1, 1'b0, 1'b0, 8'h40};
      vecs[7]  = '{8'h40, OP_NOP,  8'hAA,  1'b0, 1'b0, 1'b0, 8'h42};
      vecs[8]  = '{8'h42, OP_JUMP, 8'hFE,  1'b1, 1'b0, 1'b0, 8'hFE};
      vecs[9]  = '{8'hFE, OP_SLL,  OP_XOR, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[10] = '{8'h00, OP_BZ,   8'h77,  1'b0, 1'b0, 1'b1, 8'h02};
      vecs[11] = '{8'h02, OP_JUMP, 8'hFF,  1'b1, 1'b0, 1'b0, 8'hFF};
      vecs[12] = '{8'hFF, OP_XOR,  OP_BZ,  1'b0, 1'b0, 1'b0, 8'h01};
      for (int a = 0; a < 256; a++) mem[a] = 8'h00;
      for (int i = 0; i < 13; i++) begin
         mem[vecs[i].pc]         = vecs[i].op;
         mem[vecs[i].pc + 8'd1]  = vecs[i].arg;
      end

      rst_n = 1'b0; run = 1'b0; op_ready = 1'b0;
      jump = 1'b0; brach = 1'b0; acc_zero = 1'b0;
      wait_states = 0;
      tick();
      tick();
      checkOutput("rst_op_valid", {7'd0, op_valid}, 8'd0);
      checkOutput("rst_req", {7'd0, imem_req}, 8'd0);
      checkOutput("rst_addr", imem_addr, 8'h10);
      checkOutput("rst_pc", pc, 8'h10);

      // Startup latency: addresses 10, 11, then op_valid in the third cycle.
      rst_n = 1'b1; run = 1'b1;
      jump = 1'b1; brach = 1'b1; acc_zero = 1'b1;
      tick();
      checkOutput("start_req", {7'd0, imem_req}, 8'd1);
      checkOutput("start_addr0", imem_addr, 8'h10);
      tick();
      checkOutput("start_addr1", imem_addr, 8'h11);
      checkOutput("start_valid_early", {7'd0, op_valid}, 8'd0);
      tick();
      checkOutput("start_valid", {7'd0, op_valid}, 8'd1);

      for (int i = 0; i < 13; i++) applyStimulus(i, i == 12);

      // Reset after a full program: everything back to the reset image.
      rst_n = 1'b0;
      tick();
      checkOutput("rst2_op", op, OP_NOP);
      checkOutput("rst2_arg", arg, 8'h00);
      checkOutput("rst2_pc", pc, 8'h10);

      // Two wait states per byte, then four cycles of backpressure.
      rst_n = 1'b1; run = 1'b1; wait_states = 2;
      sb.push_back('{8'h10, OP_LDA, 8'h33});
      tick();
      for (int k = 0; k < 3; k++) begin
         checkOutput("ws_addr_op", imem_addr, 8'h10);
         checkOutput("ws_req_op", {7'd0, imem_req}, 8'd1);
         tick();
      end
      run = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checkOutput("ws_addr_arg", imem_addr, 8'h11);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         checkOutput("bp_valid", {7'd0, op_valid}, 8'd1);
         checkOutput("bp_op", op, OP_LDA);
         checkOutput("bp_arg", arg, 8'h33);
         checkOutput("bp_req", {7'd0, imem_req}, 8'd0);
         tick();
      end
      jump = 1'b0; brach = 1'b0; acc_zero = 1'b0;
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
      checkOutput("bp_next_pc", pc, 8'h12);
      checkOutput("bp_idle_valid", {7'd0, op_valid}, 8'd0);
      checkOutput("bp_idle_req", {7'd0, imem_req}, 8'd0);

      // Reset landing in FETCH_ARG, with an ack present in the reset cycle.
      wait_states = 0; run = 1'b1;
      tick();
      tick();
      checkOutput("fa_addr", imem_addr, 8'h13);
      checkOutput("fa_op", op, OP_JUMP);
      rst_n = 1'b0;
      tick();
      checkOutput("fa_rst_valid", {7'd0, op_valid}, 8'd0);
      checkOutput("fa_rst_req", {7'd0, imem_req}, 8'd0);
      checkOutput("fa_rst_pc", pc, 8'h10);
      checkOutput("fa_rst_addr", imem_addr, 8'h10);
      checkOutput("fa_rst_op", op, OP_NOP);
      rst_n = 1'b1; run = 1'b0;
      tick();
      checkOutput("fa_idle_req", {7'd0, imem_req}, 8'd0);

      tick();
      checkOutput("sb_pending", 8'(sb.size()), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
